rom_program_sequencer: RTL and testbench

- Program sequencer for the instruction ROM of the Spartan-3E test CPU.
- Owns the program counter and drives the ROM address. Latches each 28-bit instruction and executes NOP (delay) and JMP internally.
- Issues all other instructions to the execute unit over a valid/ready handshake, stalling fetch until accepted.

---
 rtl/rom_program_sequencer.sv | 122 ++++++++++++
 tb/tb_rom_program_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_program_sequencer.sv
// rtl/rom_program_sequencer.sv - instruction ROM program sequencer (PC, NOP delay, JMP, issue handshake)
// Optional single-step gating via SEQ_SINGLE_STEP_EN (adds iStep).
module rom_program_sequencer #(
  parameter logic [3:0]  P_OP_NOP   = 4'd0,
  parameter logic [3:0]  P_OP_JMP   = 4'd5,
  parameter logic [15:0] P_RESET_PC = 16'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        iStep,
`endif
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady,
  output logic        oDelayBusy
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_ISSUE, S_DELAY} state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic [27:0] ir, ir_d;
  logic [23:0] cnt, cnt_d;
  logic [27:0] inst_d;
  logic        valid_d, busy_d;
  logic        fetch_go;
  logic [3:0]  opcode;

  assign opcode   = ir[27:24];
  assign oAddress = pc;

`ifdef SEQ_SINGLE_STEP_EN
  // Each step pulse releases exactly one fetch; otherwise FETCH holds.
  assign fetch_go = iEnable & iStep;
`else
  assign fetch_go = iEnable;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_FETCH;
      pc           <= P_RESET_PC;
      ir           <= '0;
      cnt          <= '0;
      oInstruction <= '0;
      oValid       <= 1'b0;
      oDelayBusy   <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      ir           <= ir_d;
      cnt          <= cnt_d;
      oInstruction <= inst_d;
      oValid       <= valid_d;
      oDelayBusy   <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH:  if (fetch_go) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == P_OP_NOP)
          state_d = (ir[23:0] == 24'd0) ? S_FETCH : S_DELAY;
        else if (opcode == P_OP_JMP)
          state_d = S_FETCH;
        else
          state_d = S_ISSUE;
      end
      S_ISSUE:  if (iReady) state_d = S_FETCH;
      S_DELAY:  if (cnt == 24'd1) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d    = pc;
    ir_d    = ir;
    cnt_d   = cnt;
    inst_d  = oInstruction;
    valid_d = oValid;
    busy_d  = oDelayBusy;
    case (state)
      S_FETCH: if (fetch_go) ir_d = iInstruction;
      S_DECODE: begin
        if (opcode == P_OP_NOP) begin
          if (ir[23:0] == 24'd0) begin
            pc_d = pc + 16'd1;
          end else begin
            cnt_d  = ir[23:0];
            busy_d = 1'b1;
          end
        end else if (opcode == P_OP_JMP) begin
          pc_d = ir[15:0];
        end else begin
          inst_d  = ir;
          valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (iReady) begin
          valid_d = 1'b0;
          pc_d    = pc + 16'd1;
        end
      end
      S_DELAY: begin
        cnt_d = cnt - 24'd1;
        if (cnt == 24'd1) begin
          busy_d = 1'b0;
          pc_d   = pc + 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_program_sequencer.sv
// tb/tb_rom_program_sequencer.sv - directed self-checking bench for rom_program_sequencer
module tb_rom_program_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iEnable = 1'b0;
  logic        iStep = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady = 1'b0;
  logic        oDelayBusy;

  logic [27:0] rom [16];
  int passed = 0;
  int total  = 0;
  int fails  = 0;

  assign iInstruction = rom[oAddress[3:0]];

  rom_program_sequencer dut (
    .Clock(Clock),
    .Reset(Reset),
    .iEnable(iEnable),
`ifdef SEQ_SINGLE_STEP_EN
    .iStep(iStep),
`endif
    .oAddress(oAddress),
    .iInstruction(iInstruction),
    .oInstruction(oInstruction),
    .oValid(oValid),
    .iReady(iReady),
    .oDelayBusy(oDelayBusy)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 28'h0000000;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
  endtask

  int busy_cnt, valid_cnt, addr1_at, stable_cnt;
  logic [27:0] held;

  initial begin
    clear_rom();
    #2;

    // Enable low: FETCH holds, nothing issued
    rom[0] = 28'h3010100;
    iEnable = 1'b0;
    iReady  = 1'b1;
    do_reset();
    check("rst_addr", oAddress, 16'h0000);
    check("rst_valid", oValid, 1'b0);
    check("rst_busy", oDelayBusy, 1'b0);
    check("rst_inst", oInstruction, 28'h0);
    tick(5);
    check("hold_addr", oAddress, 16'h0000);
    check("hold_valid", oValid, 1'b0);

    // Single issued instruction with ready already high
    iEnable = 1'b1;
    do_reset();
    tick(1);
    check("t1_decode_valid", oValid, 1'b0);
    tick(1);
    check("t1_valid", oValid, 1'b1);
    check("t1_inst", oInstruction, 28'h3010100);
    check("t1_addr_hold", oAddress, 16'h0000);
    tick(1);
    check("t1_valid_drop", oValid, 1'b0);
    check("t1_addr_next", oAddress, 16'h0001);
    check("t1_inst_kept", oInstruction, 28'h3010100);

    // NOP 4: exactly four busy cycles, address 1 after the sixth edge
    clear_rom();
    rom[0] = 28'h0000004;
    do_reset();
    busy_cnt = 0; valid_cnt = 0; addr1_at = 0;
    for (int t = 1; t <= 7; t++) begin
      tick(1);
      if (oDelayBusy) busy_cnt++;
      if (oValid) valid_cnt++;
      if (oAddress == 16'h0001 && addr1_at == 0) addr1_at = t;
    end
    check("nop_busy_cycles", busy_cnt, 4);
    check("nop_no_valid", valid_cnt, 0);
    check("nop_addr1_edge", addr1_at, 6);

    // JMP loop at address 5 with garbage in IR[23:16]
    clear_rom();
    rom[5] = 28'h5AB0000;
    do_reset();
    valid_cnt = 0;
    for (int t = 1; t <= 24; t++) begin
      tick(1);
      if (oValid) valid_cnt++;
      if (t == 10) check("jmp_at5", oAddress, 16'h0005);
      if (t == 12) check("jmp_back0", oAddress, 16'h0000);
      if (t == 22) check("jmp_at5_again", oAddress, 16'h0005);
      if (t == 24) check("jmp_back0_again", oAddress, 16'h0000);
    end
    check("jmp_no_valid", valid_cnt, 0);

    // Stall in ISSUE for ten edges
    clear_rom();
    rom[0] = 28'h1234567;
    iReady = 1'b0;
    do_reset();
    tick(2);
    valid_cnt = oValid ? 1 : 0;
    held = oInstruction;
    check("stall_inst", held, 28'h1234567);
    stable_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick(1);
      if (oValid) valid_cnt++;
      if (oInstruction == 28'h1234567 && oAddress == 16'h0000) stable_cnt++;
    end
    iReady = 1'b1;
    tick(1);
    check("stall_valid_cycles", valid_cnt, 11);
    check("stall_stable", stable_cnt, 10);
    check("stall_release_valid", oValid, 1'b0);
    check("stall_release_addr", oAddress, 16'h0001);

    // PC wrap from 16'hFFFF
    clear_rom();
    rom[0]  = 28'h500FFFF;
    rom[15] = 28'h2000001;
    do_reset();
    tick(2);
    check("wrap_jmp_ffff", oAddress, 16'hFFFF);
    tick(2);
    check("wrap_valid", oValid, 1'b1);
    check("wrap_inst", oInstruction, 28'h2000001);
    tick(1);
    check("wrap_addr0", oAddress, 16'h0000);

    // Reset in the middle of a 100-cycle delay
    clear_rom();
    rom[0] = 28'h5000003;
    rom[3] = 28'h0000064;
    do_reset();
    tick(8);
    check("dly_busy", oDelayBusy, 1'b1);
    check("dly_addr", oAddress, 16'h0003);
    do_reset();
    check("dly_rst_busy", oDelayBusy, 1'b0);
    check("dly_rst_valid", oValid, 1'b0);
    check("dly_rst_addr", oAddress, 16'h0000);
    tick(2);
    check("dly_refetch_busy", oDelayBusy, 1'b0);

    // Reset while an instruction is offered
    clear_rom();
    rom[0] = 28'h1ABCDEF;
    iReady = 1'b0;
    do_reset();
    tick(2);
    check("iss_valid", oValid, 1'b1);
    do_reset();
    check("iss_rst_valid", oValid, 1'b0);
    check("iss_rst_inst", oInstruction, 28'h0);
    iReady = 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
    clear_rom();
    rom[0] = 28'h3000011;
    rom[1] = 28'h3000022;
    iStep = 1'b0;
    do_reset();
    valid_cnt = 0; stable_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (oValid) valid_cnt++;
      if (oAddress == 16'h0000) stable_cnt++;
    end
    check("step_frozen_valid", valid_cnt, 0);
    check("step_frozen_addr", stable_cnt, 20);
    iStep = 1'b1;
    tick(1);
    iStep = 1'b0;
    valid_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      tick(1);
      if (oValid) begin
        valid_cnt++;
        check("step_inst", oInstruction, 28'h3000011);
      end
    end
    check("step_one_issue", valid_cnt, 1);
    check("step_addr1", oAddress, 16'h0001);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
